// File: rtl/ret_addr_stack_if.sv
// Fetch <-> return address stack bundle: speculative push/pop, retirement
// commits, flush, and the top-of-stack prediction outputs.
interface ret_addr_stack_if #(
   parameter int ADDR_W = 32,
   parameter int PTR_W  = 4
);
   logic              push;
   logic [ADDR_W-1:0] push_addr;
   logic              pop;
   logic              commit_push;
   logic              commit_pop;
   logic              flush;
   logic              top_valid;
   logic [ADDR_W-1:0] top_addr;
   logic [PTR_W:0]    count;
   logic              full;
   logic              empty;

   modport master (
      output push, push_addr, pop, commit_push, commit_pop, flush,
      input  top_valid, top_addr, count, full, empty
   );

   modport slave (
      input  push, push_addr, pop, commit_push, commit_pop, flush,
      output top_valid, top_addr, count, full, empty
   );
endinterface

// File: rtl/ret_addr_stack.sv
// Speculative return address stack with optional committed-pointer repair on flush.
// Macro RAS_CHECKPOINT_EN: defined -> flush restores retired pointer/count; undefined -> flush empties.
module ret_addr_stack #(
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4,
   parameter int ADDR_W = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   ret_addr_stack_if.slave ras
);
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   C_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);

   logic [ADDR_W-1:0] entries [DEPTH];
   logic [PTR_W-1:0]  sp, sp_nxt, sp_dec;
   logic [PTR_W:0]    sc, sc_nxt;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic [PTR_W-1:0]  rp_ptr;
   logic [PTR_W:0]    rp_cnt;

   assign sp_dec = sp - P_ONE;

`ifdef RAS_CHECKPOINT_EN
   logic [PTR_W-1:0] cp, cp_nxt;
   logic [PTR_W:0]   cc, cc_nxt;

   // Retired calls/returns follow the same pointer rules, without touching entries.
   always_comb begin
      cp_nxt = cp;
      cc_nxt = cc;
      if (ras.commit_push && (!ras.commit_pop || cc == '0)) begin
         cp_nxt = cp + P_ONE;
         cc_nxt = (cc == CNT_MAX) ? cc : cc + C_ONE;
      end else if (ras.commit_pop && !ras.commit_push && cc != '0) begin
         cp_nxt = cp - P_ONE;
         cc_nxt = cc - C_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cp <= '0;
         cc <= '0;
      end else begin
         cp <= cp_nxt;
         cc <= cc_nxt;
      end
   end

   // Flush sees this cycle's commit already applied.
   assign rp_ptr = cp_nxt;
   assign rp_cnt = cc_nxt;
`else
   logic unused_commit;
   assign unused_commit = ras.commit_push ^ ras.commit_pop;
   assign rp_ptr        = '0;
   assign rp_cnt        = '0;
`endif

   always_comb begin
      sp_nxt = sp;
      sc_nxt = sc;
      wr_en  = 1'b0;
      wr_idx = sp;
      if (ras.flush) begin
         sp_nxt = rp_ptr;
         sc_nxt = rp_cnt;
      end else if (ras.push && ras.pop && sc != '0) begin
         wr_en  = 1'b1;
         wr_idx = sp_dec;
      end else if (ras.push) begin
         // Push when full overwrites the oldest slot as sp wraps.
         wr_en  = 1'b1;
         sp_nxt = sp + P_ONE;
         sc_nxt = (sc == CNT_MAX) ? sc : sc + C_ONE;
      end else if (ras.pop && sc != '0) begin
         sp_nxt = sp_dec;
         sc_nxt = sc - C_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp <= '0;
         sc <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         sp <= sp_nxt;
         sc <= sc_nxt;
         if (wr_en) entries[wr_idx] <= ras.push_addr;
      end
   end

   assign ras.top_valid = (sc != '0);
   assign ras.top_addr  = entries[sp_dec];
   assign ras.count     = sc;
   assign ras.full      = (sc == CNT_MAX);
   assign ras.empty     = (sc == '0);
endmodule

// File: tb/tb_ret_addr_stack.sv
// Self-checking bench for ret_addr_stack: directed scenarios plus random traffic
// compared against a circular-buffer reference model.
module tb_ret_addr_stack;
   localparam int DEPTH  = 16;
   localparam int PTR_W  = 4;
   localparam int ADDR_W = 32;
`ifdef RAS_CHECKPOINT_EN
   localparam bit CKPT = 1'b1;
`else
   localparam bit CKPT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   ret_addr_stack_if #(.ADDR_W(ADDR_W), .PTR_W(PTR_W)) ras();

   ret_addr_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ras     (ras)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] m_mem [DEPTH];
   int m_sp, m_sc, m_cp, m_cc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void adv(input bit pu, input bit po, input int p, input int c,
                               output int np, output int nc);
      np = p;
      nc = c;
      if (pu && (!po || c == 0)) begin
         np = (p + 1) % DEPTH;
         nc = (c < DEPTH) ? c + 1 : DEPTH;
      end else if (po && !pu && c > 0) begin
         np = (p + DEPTH - 1) % DEPTH;
         nc = c - 1;
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_sp = 0; m_sc = 0; m_cp = 0; m_cc = 0;
   endtask

   task automatic model_step(input bit pu, input bit po, input logic [31:0] a,
                             input bit cpu, input bit cpo, input bit fl);
      int np, nc;
      if (CKPT) begin
         adv(cpu, cpo, m_cp, m_cc, np, nc);
         m_cp = np; m_cc = nc;
      end
      if (fl) begin
         m_sp = CKPT ? m_cp : 0;
         m_sc = CKPT ? m_cc : 0;
      end else begin
         if (pu && po && m_sc > 0) m_mem[(m_sp + DEPTH - 1) % DEPTH] = a;
         else if (pu) m_mem[m_sp] = a;
         adv(pu, po, m_sp, m_sc, np, nc);
         m_sp = np; m_sc = nc;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".count"}, 64'(ras.count), 64'(m_sc));
      chk({tag, ".valid"}, 64'(ras.top_valid), 64'(m_sc != 0));
      chk({tag, ".empty"}, 64'(ras.empty), 64'(m_sc == 0));
      chk({tag, ".full"}, 64'(ras.full), 64'(m_sc == DEPTH));
      chk({tag, ".top"}, 64'(ras.top_addr), 64'(m_mem[(m_sp + DEPTH - 1) % DEPTH]));
   endtask

   task automatic cyc(input string tag, input bit pu, input bit po, input logic [31:0] a,
                      input bit cpu = 0, input bit cpo = 0, input bit fl = 0);
      ras.push = pu; ras.pop = po; ras.push_addr = a;
      ras.commit_push = cpu; ras.commit_pop = cpo; ras.flush = fl;
      @(posedge clk);
      model_step(pu, po, a, cpu, cpo, fl);
      #1;
      ras.push = 0; ras.pop = 0; ras.commit_push = 0; ras.commit_pop = 0; ras.flush = 0;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      #2;
      check_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      ras.push = 0; ras.pop = 0; ras.push_addr = '0;
      ras.commit_push = 0; ras.commit_pop = 0; ras.flush = 0;
      reset_n = 1'b1;
      #3;
      do_reset();

      // Reset then push
      cyc("p1", 1, 0, 32'h100);
      cyc("p2", 1, 0, 32'h200);
      cyc("p3", 1, 0, 32'h300);
      chk("rp_count3", 64'(ras.count), 64'd3);
      chk("rp_top300", 64'(ras.top_addr), 64'h300);
      cyc("pop1", 0, 1, '0);
      cyc("pop2", 0, 1, '0);
      chk("rp_top100", 64'(ras.top_addr), 64'h100);
      chk("rp_count1", 64'(ras.count), 64'd1);

      // Overflow
      do_reset();
      for (int k = 0; k <= 16; k++) cyc("ovf_push", 1, 0, 32'h1000 + 32'(4 * k));
      chk("ovf_full", 64'(ras.full), 64'd1);
      chk("ovf_count", 64'(ras.count), 64'd16);
      chk("ovf_top", 64'(ras.top_addr), 64'h1040);
      for (int k = 0; k < 15; k++) cyc("ovf_pop", 0, 1, '0);
      chk("ovf_last", 64'(ras.top_addr), 64'h1004);
      cyc("ovf_pop16", 0, 1, '0);
      chk("ovf_empty", 64'(ras.empty), 64'd1);

      // Underflow
      cyc("udf_pop", 0, 1, '0);
      chk("udf_count", 64'(ras.count), 64'd0);
      chk("udf_valid", 64'(ras.top_valid), 64'd0);
      chk("udf_noX", 64'($isunknown({ras.top_addr, ras.count, ras.full, ras.empty})), 64'd0);
      cyc("udf_both", 1, 1, 32'h44);
      chk("udf_count1", 64'(ras.count), 64'd1);
      chk("udf_top44", 64'(ras.top_addr), 64'h44);

      // Replace top
      do_reset();
      cyc("rep_a", 1, 0, 32'hA);
      cyc("rep_b", 1, 0, 32'hB);
      cyc("rep_c", 1, 1, 32'hC);
      chk("rep_count", 64'(ras.count), 64'd2);
      chk("rep_top", 64'(ras.top_addr), 64'hC);
      cyc("rep_pop", 0, 1, '0);
      chk("rep_topA", 64'(ras.top_addr), 64'hA);

      // Flush repair
      do_reset();
      cyc("fl_p1", 1, 0, 32'h5000, 1, 0, 0);
      cyc("fl_p2", 1, 0, 32'h6000);
      cyc("fl_fl", 0, 0, '0, 0, 0, 1);
      if (CKPT) begin
         chk("fl_count", 64'(ras.count), 64'd1);
         chk("fl_top", 64'(ras.top_addr), 64'h5000);
      end else begin
         chk("fl_count", 64'(ras.count), 64'd0);
         chk("fl_empty", 64'(ras.empty), 64'd1);
      end

      // Flush with same-cycle commit pop
      do_reset();
      cyc("fp_p", 1, 0, 32'h7000, 1, 0, 0);
      cyc("fp_p2", 1, 0, 32'h7100);
      cyc("fp_fl", 1, 0, 32'h7200, 0, 1, 1);
      chk("fp_count", 64'(ras.count), 64'd0);

      // Async reset mid push stream
      cyc("ar_p1", 1, 0, 32'h8000);
      cyc("ar_p2", 1, 0, 32'h8004);
      ras.push = 1; ras.push_addr = 32'h8008;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("ar_count", 64'(ras.count), 64'd0);
      chk("ar_valid", 64'(ras.top_valid), 64'd0);
      chk("ar_top", 64'(ras.top_addr), 64'd0);
      chk("ar_full", 64'(ras.full), 64'd0);
      chk("ar_empty", 64'(ras.empty), 64'd1);
      ras.push = 0;
      @(negedge clk);
      reset_n = 1'b1;
      cyc("ar_first", 1, 0, 32'h900);
      chk("ar_first_count", 64'(ras.count), 64'd1);
      chk("ar_first_top", 64'(ras.top_addr), 64'h900);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit pu, po, cpu, cpo, fl;
         pu  = ($urandom_range(99) < 50);
         po  = ($urandom_range(99) < 40);
         cpu = ($urandom_range(99) < 20);
         cpo = ($urandom_range(99) < 20);
         fl  = ($urandom_range(99) < 3);
         cyc("rnd", pu, po, $urandom, cpu, cpo, fl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
